// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a small FIFO of long-latency results.
// Optional starvation guard enabled by defining LUCID64_WB_STARVE_GUARD_EN.
module rf_write_arbiter #(
    parameter int LL_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              wb_rd_wr_en_i,
    input  logic [4:0]                        wb_rd_idx_i,
    input  logic [63:0]                       wb_rd_data_i,
    input  logic                              ll_valid_i,
    input  logic [4:0]                        ll_rd_idx_i,
    input  logic [63:0]                       ll_rd_data_i,
    output logic                              ll_ready_o,
    output logic                              rf_wr_en_o,
    output logic [4:0]                        rf_rd_idx_o,
    output logic [63:0]                       rf_rd_data_o,
    output logic                              wb_stall_o,
    output logic                              ll_pending_o,
    output logic [$clog2(LL_FIFO_DEPTH):0]    ll_count_o
);

    localparam int PTR_W = $clog2(LL_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (LL_FIFO_DEPTH < 2 || (LL_FIFO_DEPTH & (LL_FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1)
    begin : g_param_check
        $error("rf_write_arbiter: LL_FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    logic [4:0]       idx_mem  [LL_FIFO_DEPTH];
    logic [63:0]      data_mem [LL_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic fifo_empty;
    logic fifo_full;
    logic ll_push;
    logic ll_pop;
    logic wb_grant;
    logic forced_grant;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(LL_FIFO_DEPTH));

    // Ready looks only at registered occupancy, so a same-cycle pop never opens a slot.
    assign ll_ready_o = !rst_i && !fifo_full;
    assign ll_push    = ll_valid_i && ll_ready_o && (ll_rd_idx_i != 5'd0);

    assign wb_grant = !rst_i && wb_rd_wr_en_i && (wb_rd_idx_i != 5'd0) && !forced_grant;
    assign ll_pop   = !rst_i && !wb_grant && !fifo_empty;

`ifdef LUCID64_WB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_q, starve_d;

    assign forced_grant = !rst_i && !fifo_empty && (starve_q == STARVE_W'(STARVE_LIMIT));
    // A non-empty buffer that is not popped means the pipeline took the port this cycle.
    assign starve_d     = (ll_pop || fifo_empty) ? '0 : starve_q + 1'b1;
    assign wb_stall_o   = forced_grant;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign forced_grant = 1'b0;
    assign wb_stall_o   = 1'b0;
`endif

    assign wr_ptr_d = ll_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = ll_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign count_d  = count_q + CNT_W'(ll_push) - CNT_W'(ll_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (ll_push) begin
            idx_mem[wr_ptr_q]  <= ll_rd_idx_i;
            data_mem[wr_ptr_q] <= ll_rd_data_i;
        end
    end

    always_comb begin
        rf_wr_en_o   = 1'b0;
        rf_rd_idx_o  = 5'd0;
        rf_rd_data_o = 64'd0;
        if (wb_grant) begin
            rf_wr_en_o   = 1'b1;
            rf_rd_idx_o  = wb_rd_idx_i;
            rf_rd_data_o = wb_rd_data_i;
        end else if (ll_pop) begin
            rf_wr_en_o   = 1'b1;
            rf_rd_idx_o  = idx_mem[rd_ptr_q];
            rf_rd_data_o = data_mem[rd_ptr_q];
        end
    end

    assign ll_pending_o = !rst_i && !fifo_empty;
    assign ll_count_o   = rst_i ? '0 : count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model (guard mode follows LUCID64_WB_STARVE_GUARD_EN).
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef LUCID64_WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          wb_rd_wr_en_i = 1'b0;
    logic [4:0]    wb_rd_idx_i = '0;
    logic [63:0]   wb_rd_data_i = '0;
    logic          ll_valid_i = 1'b0;
    logic [4:0]    ll_rd_idx_i = '0;
    logic [63:0]   ll_rd_data_i = '0;
    logic          ll_ready_o;
    logic          rf_wr_en_o;
    logic [4:0]    rf_rd_idx_o;
    logic [63:0]   rf_rd_data_o;
    logic          wb_stall_o;
    logic          ll_pending_o;
    logic [CW-1:0] ll_count_o;

    int tests_run = 0;
    int failed    = 0;

    rf_write_arbiter #(.LL_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_rd_wr_en_i(wb_rd_wr_en_i), .wb_rd_idx_i(wb_rd_idx_i), .wb_rd_data_i(wb_rd_data_i),
        .ll_valid_i(ll_valid_i), .ll_rd_idx_i(ll_rd_idx_i), .ll_rd_data_i(ll_rd_data_i),
        .ll_ready_o(ll_ready_o), .rf_wr_en_o(rf_wr_en_o), .rf_rd_idx_o(rf_rd_idx_o),
        .rf_rd_data_o(rf_rd_data_o), .wb_stall_o(wb_stall_o), .ll_pending_o(ll_pending_o),
        .ll_count_o(ll_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: pending results as a queue, plus the starvation count.
    typedef struct packed { logic [4:0] idx; logic [63:0] data; } ent_t;
    ent_t q[$];
    int   starve = 0;

    logic          exp_wr_en, exp_ready, exp_stall, exp_pending;
    logic [4:0]    exp_idx;
    logic [63:0]   exp_data;
    logic [CW-1:0] exp_count;
    bit            mdl_pop, mdl_push;

    task automatic model_eval();
        bit forced, wbg;
        exp_wr_en = 0; exp_idx = '0; exp_data = '0; exp_ready = 0;
        exp_stall = 0; exp_pending = 0; exp_count = '0; mdl_pop = 0; mdl_push = 0;
        if (!rst_i) begin
            forced      = GUARD && (starve == LIMIT) && (q.size() > 0);
            wbg         = wb_rd_wr_en_i && (wb_rd_idx_i != 0) && !forced;
            mdl_pop     = !wbg && (q.size() > 0);
            exp_stall   = forced;
            exp_count   = CW'(q.size());
            exp_pending = (q.size() > 0);
            exp_ready   = (q.size() < DEPTH);
            mdl_push    = ll_valid_i && exp_ready && (ll_rd_idx_i != 0);
            if (wbg) begin
                exp_wr_en = 1; exp_idx = wb_rd_idx_i; exp_data = wb_rd_data_i;
            end else if (mdl_pop) begin
                exp_wr_en = 1; exp_idx = q[0].idx; exp_data = q[0].data;
            end
        end
    endtask

    task automatic model_commit();
        bit was_empty;
        if (rst_i) begin
            q.delete();
            starve = 0;
        end else begin
            was_empty = (q.size() == 0);
            if (mdl_pop) void'(q.pop_front());
            if (mdl_push) q.push_back({ll_rd_idx_i, ll_rd_data_i});
            starve = (mdl_pop || was_empty) ? 0 : starve + 1;
        end
    endtask

    // Called at a falling edge: apply inputs, predict, then settle before sampling.
    task automatic step(input bit rst, input bit wen, input logic [4:0] widx, input logic [63:0] wdata,
                        input bit lv, input logic [4:0] lidx, input logic [63:0] ldata);
        rst_i = rst; wb_rd_wr_en_i = wen; wb_rd_idx_i = widx; wb_rd_data_i = wdata;
        ll_valid_i = lv; ll_rd_idx_i = lidx; ll_rd_data_i = ldata;
        model_eval();
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_commit();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 5'd7, 64'h77, 1, 5'd9, 64'h99);
            tests_run++;
            if ({rf_wr_en_o, ll_ready_o, wb_stall_o, ll_pending_o} !== 4'b0000) begin
                failed++;
                $display("FAIL reset_outputs got wr=%0b rdy=%0b stall=%0b pend=%0b want all 0",
                         rf_wr_en_o, ll_ready_o, wb_stall_o, ll_pending_o);
            end
            tick();
        end
        step(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (ll_count_o !== '0 || ll_ready_o !== 1'b1) begin
            failed++;
            $display("FAIL post_reset got count=%0d rdy=%0b want count=0 rdy=1", ll_count_o, ll_ready_o);
        end
        tick();
    endtask

    task automatic test_single_push();
        step(0, 0, 0, 0, 1, 5'd5, 64'hA);
        tests_run++;
        if (rf_wr_en_o !== 1'b0) begin
            failed++;
            $display("FAIL no_bypass got wr=%0b want 0", rf_wr_en_o);
        end
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (rf_wr_en_o !== 1'b1 || rf_rd_idx_o !== 5'd5 || rf_rd_data_o !== 64'hA || ll_count_o !== CW'(1)) begin
            failed++;
            $display("FAIL single_write got wr=%0b idx=%0d data=%0h cnt=%0d want 1 5 a 1",
                     rf_wr_en_o, rf_rd_idx_o, rf_rd_data_o, ll_count_o);
        end
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (ll_count_o !== '0 || rf_wr_en_o !== 1'b0 || rf_rd_idx_o !== 5'd0 || rf_rd_data_o !== 64'd0) begin
            failed++;
            $display("FAIL single_drain got cnt=%0d wr=%0b idx=%0d data=%0h want 0 0 0 0",
                     ll_count_o, rf_wr_en_o, rf_rd_idx_o, rf_rd_data_o);
        end
        tick();
    endtask

    task automatic test_fill_order();
        step(0, 1, 5'd10, 64'h1010, 1, 5'd3, 64'h3333);
        tests_run++;
        if (rf_rd_idx_o !== 5'd10) begin
            failed++;
            $display("FAIL fill_wb_prio got idx=%0d want 10", rf_rd_idx_o);
        end
        tick();
        step(0, 1, 5'd11, 64'h1111, 1, 5'd4, 64'h4444);
        tick();
        step(0, 1, 5'd12, 64'h1212, 1, 5'd9, 64'h9999);
        tests_run++;
        if (ll_ready_o !== 1'b0 || ll_count_o !== CW'(2) || rf_rd_idx_o !== 5'd12) begin
            failed++;
            $display("FAIL fill_full got rdy=%0b cnt=%0d idx=%0d want 0 2 12", ll_ready_o, ll_count_o, rf_rd_idx_o);
        end
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (rf_wr_en_o !== 1'b1 || rf_rd_idx_o !== 5'd3 || rf_rd_data_o !== 64'h3333) begin
            failed++;
            $display("FAIL fill_first got wr=%0b idx=%0d data=%0h want 1 3 3333", rf_wr_en_o, rf_rd_idx_o, rf_rd_data_o);
        end
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (rf_wr_en_o !== 1'b1 || rf_rd_idx_o !== 5'd4 || rf_rd_data_o !== 64'h4444) begin
            failed++;
            $display("FAIL fill_second got wr=%0b idx=%0d data=%0h want 1 4 4444", rf_wr_en_o, rf_rd_idx_o, rf_rd_data_o);
        end
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (ll_count_o !== '0 || rf_wr_en_o !== 1'b0) begin
            failed++;
            $display("FAIL fill_empty got cnt=%0d wr=%0b want 0 0 (full-time push must be dropped)", ll_count_o, rf_wr_en_o);
        end
        tick();
    endtask

    task automatic test_zero_idx();
        step(0, 1, 5'd0, 64'hDEAD, 1, 5'd0, 64'hBEEF);
        tests_run++;
        if (rf_wr_en_o !== 1'b0 || ll_count_o !== '0) begin
            failed++;
            $display("FAIL zero_same got wr=%0b cnt=%0d want 0 0", rf_wr_en_o, ll_count_o);
        end
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (rf_wr_en_o !== 1'b0 || ll_count_o !== '0 || ll_pending_o !== 1'b0) begin
            failed++;
            $display("FAIL zero_next got wr=%0b cnt=%0d pend=%0b want 0 0 0", rf_wr_en_o, ll_count_o, ll_pending_o);
        end
        tick();
    endtask

    task automatic test_push_pop();
        step(0, 0, 0, 0, 1, 5'd6, 64'h66);
        tick();
        step(0, 0, 0, 0, 1, 5'd7, 64'h77);
        tests_run++;
        if (rf_rd_idx_o !== 5'd6 || rf_rd_data_o !== 64'h66 || ll_count_o !== CW'(1)) begin
            failed++;
            $display("FAIL pushpop_head got idx=%0d data=%0h cnt=%0d want 6 66 1", rf_rd_idx_o, rf_rd_data_o, ll_count_o);
        end
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (ll_count_o !== CW'(1) || rf_rd_idx_o !== 5'd7 || rf_rd_data_o !== 64'h77) begin
            failed++;
            $display("FAIL pushpop_next got cnt=%0d idx=%0d data=%0h want 1 7 77", ll_count_o, rf_rd_idx_o, rf_rd_data_o);
        end
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_starvation();
        logic        want_stall;
        logic [4:0]  want_idx;
        step(0, 1, 5'd1, 64'h1, 1, 5'd12, 64'hC0DE);
        tick();
        for (int c = 1; c <= 12; c++) begin
            step(0, 1, 5'd20, 64'(c), 0, 0, 0);
            want_stall = GUARD && (c == 9);
            want_idx   = want_stall ? 5'd12 : 5'd20;
            tests_run++;
            if (wb_stall_o !== want_stall || rf_rd_idx_o !== want_idx) begin
                failed++;
                $display("FAIL starve_c%0d got stall=%0b idx=%0d want stall=%0b idx=%0d",
                         c, wb_stall_o, rf_rd_idx_o, want_stall, want_idx);
            end
            tick();
        end
        step(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (rf_wr_en_o !== !GUARD || ll_count_o !== CW'(GUARD ? 0 : 1)) begin
            failed++;
            $display("FAIL starve_after got wr=%0b cnt=%0d want wr=%0b cnt=%0d",
                     rf_wr_en_o, ll_count_o, !GUARD, GUARD ? 0 : 1);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        step(0, 1, 5'd2, 64'h2, 1, 5'd13, 64'hD);
        tick();
        step(0, 1, 5'd2, 64'h2, 1, 5'd14, 64'hE);
        tick();
        step(0, 1, 5'd2, 64'h2, 0, 0, 0);
        tests_run++;
        if (ll_count_o !== CW'(2)) begin
            failed++;
            $display("FAIL rstmid_fill got cnt=%0d want 2", ll_count_o);
        end
        tick();
        step(1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if ({rf_wr_en_o, wb_stall_o, ll_pending_o} !== 3'b000 || ll_count_o !== '0) begin
            failed++;
            $display("FAIL rstmid_during got wr=%0b stall=%0b pend=%0b cnt=%0d want 0",
                     rf_wr_en_o, wb_stall_o, ll_pending_o, ll_count_o);
        end
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if ({rf_wr_en_o, wb_stall_o, ll_pending_o} !== 3'b000 || ll_count_o !== '0) begin
            failed++;
            $display("FAIL rstmid_after got wr=%0b stall=%0b pend=%0b cnt=%0d want 0",
                     rf_wr_en_o, wb_stall_o, ll_pending_o, ll_count_o);
        end
        tick();
    endtask

    task automatic test_random();
        logic [74:0] got, want;
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 {$urandom, $urandom},
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 {$urandom, $urandom});
            got  = {rf_wr_en_o, rf_rd_idx_o, rf_rd_data_o, ll_ready_o, wb_stall_o, ll_pending_o, 2'(ll_count_o)};
            want = {exp_wr_en, exp_idx, exp_data, exp_ready, exp_stall, exp_pending, 2'(exp_count)};
            tests_run++;
            if (got !== want) begin
                failed++;
                $display("FAIL random_%0d got wr=%0b idx=%0d data=%0h rdy=%0b stall=%0b pend=%0b cnt=%0d want wr=%0b idx=%0d data=%0h rdy=%0b stall=%0b pend=%0b cnt=%0d",
                         n, rf_wr_en_o, rf_rd_idx_o, rf_rd_data_o, ll_ready_o, wb_stall_o, ll_pending_o, ll_count_o,
                         exp_wr_en, exp_idx, exp_data, exp_ready, exp_stall, exp_pending, exp_count);
            end
            tick();
        end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_single_push();
        test_fill_order();
        test_zero_idx();
        test_push_pop();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
